// File: rtl/squeue_param_queue_if.sv
// ============================================================================
// Module   : squeue_param_queue_if
// Purpose  : Method-style enqueue/dequeue bundle for squeue_param_queue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface squeue_param_queue_if #(
    parameter int p_msg_nbits   = 8,
    parameter int p_num_entries = 4
);
    localparam int c_cw = $clog2(p_num_entries + 1);

    logic [p_msg_nbits-1:0] enq_msg;
    logic                   enq_en;
    logic                   enq_rdy;
    logic [p_msg_nbits-1:0] deq_msg;
    logic                   deq_en;
    logic                   deq_rdy;
    logic [c_cw-1:0]        num_free;

    modport master (
        output enq_msg, enq_en, deq_en,
        input  enq_rdy, deq_msg, deq_rdy, num_free
    );

    modport slave (
        input  enq_msg, enq_en, deq_en,
        output enq_rdy, deq_msg, deq_rdy, num_free
    );
endinterface

`default_nettype wire

// File: rtl/squeue_param_queue.sv
// ============================================================================
// Module   : squeue_param_queue
// Purpose  : Parametrised-depth circular-buffer queue, NORMAL/PIPE/BYPASS modes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module squeue_param_queue #(
    parameter int p_msg_nbits   = 8,
    parameter int p_num_entries = 4,
    parameter int p_mode        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    squeue_param_queue_if.slave     qif
);
    localparam int c_mode_pipe   = 1;
    localparam int c_mode_bypass = 2;
    localparam int c_pw = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int c_cw = $clog2(p_num_entries + 1);
    localparam logic [c_pw-1:0] c_last  = c_pw'(p_num_entries - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(p_num_entries);

    logic [p_msg_nbits-1:0] r_mem [p_num_entries];
    logic [c_pw-1:0]        r_head;
    logic [c_pw-1:0]        r_tail;
    logic [c_cw-1:0]        r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_enq_rdy;
    logic                   w_deq_rdy;
    logic                   w_bypass;
    logic                   w_enq_fire;
    logic                   w_deq_fire;
    logic [p_msg_nbits-1:0] w_deq_msg;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_enq_rdy = !w_full;
        w_deq_rdy = !w_empty;
        if (p_mode == c_mode_pipe) begin
            w_enq_rdy = !w_full || qif.deq_en;
        end else if (p_mode == c_mode_bypass) begin
            w_deq_rdy = !w_empty || qif.enq_en;
        end
    end

    // A bypassed transfer passes straight through and leaves the buffer untouched.
    assign w_bypass   = (p_mode == c_mode_bypass) && w_empty && qif.enq_en && qif.deq_en;
    assign w_enq_fire = qif.enq_en && w_enq_rdy && !w_bypass;
    assign w_deq_fire = qif.deq_en && w_deq_rdy && !w_bypass;

    always_comb begin
        w_deq_msg = '0;
        if (qif.deq_en && !w_empty) begin
            w_deq_msg = r_mem[r_head];
        end else if (w_bypass) begin
            w_deq_msg = qif.enq_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= f_next(r_tail);
            end
            if (w_deq_fire) begin
                r_head <= f_next(r_head);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_enq_fire) begin
            r_mem[r_tail] <= qif.enq_msg;
        end
    end

    assign qif.enq_rdy  = w_enq_rdy;
    assign qif.deq_rdy  = w_deq_rdy;
    assign qif.deq_msg  = w_deq_msg;
    assign qif.num_free = c_depth - r_count;

endmodule

`default_nettype wire

// File: tb/tb_squeue_param_queue.sv
// ============================================================================
// Module   : tb_squeue_param_queue
// Purpose  : Directed and random checks of squeue_param_queue against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_squeue_param_queue;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] mq[$];

    // Instance set: 0=N4 NORMAL, 1=N3 NORMAL, 2=N2 PIPE, 3=N4 BYPASS, 4=N1 NORMAL 32-bit
    squeue_param_queue_if #(.p_msg_nbits(8),  .p_num_entries(4)) if0();
    squeue_param_queue_if #(.p_msg_nbits(8),  .p_num_entries(3)) if1();
    squeue_param_queue_if #(.p_msg_nbits(8),  .p_num_entries(2)) if2();
    squeue_param_queue_if #(.p_msg_nbits(8),  .p_num_entries(4)) if3();
    squeue_param_queue_if #(.p_msg_nbits(32), .p_num_entries(1)) if4();

    squeue_param_queue #(.p_msg_nbits(8),  .p_num_entries(4), .p_mode(0))
        u0 (.clk(clk), .reset(reset), .qif(if0));
    squeue_param_queue #(.p_msg_nbits(8),  .p_num_entries(3), .p_mode(0))
        u1 (.clk(clk), .reset(reset), .qif(if1));
    squeue_param_queue #(.p_msg_nbits(8),  .p_num_entries(2), .p_mode(1))
        u2 (.clk(clk), .reset(reset), .qif(if2));
    squeue_param_queue #(.p_msg_nbits(8),  .p_num_entries(4), .p_mode(2))
        u3 (.clk(clk), .reset(reset), .qif(if3));
    squeue_param_queue #(.p_msg_nbits(32), .p_num_entries(1), .p_mode(0))
        u4 (.clk(clk), .reset(reset), .qif(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int f_n(input int id);
        case (id)
            0: return 4;
            1: return 3;
            2: return 2;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int f_mode(input int id);
        case (id)
            2: return 1;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] f_mask(input int id);
        return (id == 4) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic e, input logic [31:0] m, input logic d);
        if0.enq_en = 1'b0; if0.deq_en = 1'b0; if0.enq_msg = '0;
        if1.enq_en = 1'b0; if1.deq_en = 1'b0; if1.enq_msg = '0;
        if2.enq_en = 1'b0; if2.deq_en = 1'b0; if2.enq_msg = '0;
        if3.enq_en = 1'b0; if3.deq_en = 1'b0; if3.enq_msg = '0;
        if4.enq_en = 1'b0; if4.deq_en = 1'b0; if4.enq_msg = '0;
        case (id)
            0: begin if0.enq_en = e; if0.deq_en = d; if0.enq_msg = m[7:0]; end
            1: begin if1.enq_en = e; if1.deq_en = d; if1.enq_msg = m[7:0]; end
            2: begin if2.enq_en = e; if2.deq_en = d; if2.enq_msg = m[7:0]; end
            3: begin if3.enq_en = e; if3.deq_en = d; if3.enq_msg = m[7:0]; end
            default: begin if4.enq_en = e; if4.deq_en = d; if4.enq_msg = m; end
        endcase
    endtask

    task automatic read_out(input int id, output logic er, output logic dr,
                            output logic [31:0] dm, output logic [31:0] nf);
        case (id)
            0: begin er = if0.enq_rdy; dr = if0.deq_rdy; dm = 32'(if0.deq_msg); nf = 32'(if0.num_free); end
            1: begin er = if1.enq_rdy; dr = if1.deq_rdy; dm = 32'(if1.deq_msg); nf = 32'(if1.num_free); end
            2: begin er = if2.enq_rdy; dr = if2.deq_rdy; dm = 32'(if2.deq_msg); nf = 32'(if2.num_free); end
            3: begin er = if3.enq_rdy; dr = if3.deq_rdy; dm = 32'(if3.deq_msg); nf = 32'(if3.num_free); end
            default: begin er = if4.enq_rdy; dr = if4.deq_rdy; dm = if4.deq_msg; nf = 32'(if4.num_free); end
        endcase
    endtask

    // One clock of stimulus on one instance: predict outputs from the queue
    // contents, compare mid-cycle, then apply the fire rules to the model.
    task automatic step(input int id, input logic e, input logic [31:0] m, input logic d);
        logic        er, dr, eer, edr, full, empty, byp;
        logic [31:0] dm, nf, mm, edm;
        int          n, mode, cnt;
        n     = f_n(id);
        mode  = f_mode(id);
        mm    = m & f_mask(id);
        drive(id, e, mm, d);
        #4;
        read_out(id, er, dr, dm, nf);
        cnt   = mq.size();
        full  = (cnt == n);
        empty = (cnt == 0);
        eer   = (mode == 1) ? (!full || d) : !full;
        edr   = (mode == 2) ? (!empty || e) : !empty;
        byp   = (mode == 2) && empty && e && d;
        if (!d)          edm = 32'h0;
        else if (!empty) edm = mq[0];
        else if (byp)    edm = mm;
        else             edm = 32'h0;
        chk($sformatf("q%0d enq_rdy", id),  {31'h0, er}, {31'h0, eer});
        chk($sformatf("q%0d deq_rdy", id),  {31'h0, dr}, {31'h0, edr});
        chk($sformatf("q%0d deq_msg", id),  dm, edm);
        chk($sformatf("q%0d num_free", id), nf, 32'(n - cnt));
        @(posedge clk);
        if (!byp) begin
            if (d && edr) void'(mq.pop_front());
            if (e && eer) mq.push_back(mm);
        end
        #1;
    endtask

    task automatic do_reset(input int id, input logic e, input logic d);
        drive(id, e, $urandom, d);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0);
        mq.delete();
    endtask

    localparam bit [0:15] c_t2e = 16'b1111_0111_1011_0000;
    localparam bit [0:15] c_t2d = 16'b0011_1101_0110_1111;

    initial begin
        int mc;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        // Fill and drain a depth-4 NORMAL queue
        do_reset(0, 1'b0, 1'b0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h11, 0);
        step(0, 1, 32'h22, 0);
        step(0, 1, 32'h33, 0);
        step(0, 1, 32'h44, 0);
        step(0, 1, 32'h55, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Pointer wrap on depth 3 with dual-fire cycles at count 1 and 2
        do_reset(1, 1'b0, 1'b0);
        mc = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, c_t2e[i], 32'(mc), c_t2d[i]);
            if (c_t2e[i]) mc++;
        end
        step(1, 0, 0, 0);

        // PIPE: enqueue into a full queue while dequeueing
        do_reset(2, 1'b0, 1'b0);
        step(2, 1, 32'hA0, 0);
        step(2, 1, 32'hA1, 0);
        step(2, 1, 32'hA2, 1);
        step(2, 0, 0, 0);
        step(2, 1, 32'hA3, 0);
        step(2, 0, 0, 1);
        step(2, 0, 0, 1);
        step(2, 0, 0, 0);

        // BYPASS on empty versus NORMAL under identical stimulus
        do_reset(3, 1'b1, 1'b1);
        step(3, 1, 32'h5A, 1);
        step(3, 0, 0, 0);
        step(3, 1, 32'h61, 0);
        step(3, 1, 32'h62, 1);
        step(3, 0, 0, 1);
        step(3, 0, 0, 0);
        do_reset(0, 1'b0, 1'b0);
        step(0, 1, 32'h5A, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Reset with contents held and an enqueue pending
        do_reset(0, 1'b0, 1'b0);
        step(0, 1, 32'h01, 0);
        step(0, 1, 32'h02, 0);
        step(0, 1, 32'h03, 0);
        do_reset(0, 1'b1, 1'b0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h77, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Depth 1, 32-bit messages
        do_reset(4, 1'b0, 1'b0);
        step(4, 1, 32'hDEAD_BEEF, 0);
        step(4, 1, 32'h1234_5678, 0);
        step(4, 0, 0, 1);
        step(4, 0, 0, 1);
        step(4, 0, 0, 0);
        for (int i = 0; i < 1000; i++)
            step(4, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

        // Random traffic on the remaining modes, including protocol violations
        for (int id = 0; id < 4; id++) begin
            do_reset(id, 1'b0, 1'b0);
            for (int i = 0; i < 300; i++)
                step(id, 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
